// File: rtl/bus_cycle_controller_pkg.sv
// Shared definitions for the bus cycle controller: FSM state encodings,
// cycle-type codes, counter width and the strobe decode helper.
package bus_cycle_controller_pkg;

  localparam int WS_BITS     = 4;
  localparam int NUM_STROBES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    STROBE  = 2'b01,
    RELEASE = 2'b10
  } bus_state_t;

  // Bit 1 selects I/O space, bit 0 selects write; also the strobe vector index.
  typedef enum logic [1:0] {
    MEMRD = 2'b00,
    MEMWR = 2'b01,
    IORD  = 2'b10,
    IOWR  = 2'b11
  } cycle_type_t;

  function automatic logic [NUM_STROBES-1:0] strobe_pattern(input cycle_type_t cyc);
    logic [NUM_STROBES-1:0] pattern;
    pattern = '1;
    pattern[cyc] = 1'b0;
    return pattern;
  endfunction

  function automatic logic is_mem_cycle(input cycle_type_t cyc);
    return (cyc == MEMRD) || (cyc == MEMWR);
  endfunction

endpackage

// File: rtl/bus_cycle_controller_if.sv
// Sequencer request fields and system-bus strobes seen by the bus cycle controller.
// The controller connects through the master modport; the sequencer/bus side uses slave.
interface bus_cycle_controller_if;

  logic nmem;
  logic nio;
  logic nr;
  logic nwen;
  logic nhalt;
  logic nwaitext;

  logic nmemrd;
  logic nmemwr;
  logic niord;
  logic niowr;
  logic nws;
  logic nbuserr;
  logic busy;

  modport master (
    input  nmem, nio, nr, nwen, nhalt, nwaitext,
    output nmemrd, nmemwr, niord, niowr, nws, nbuserr, busy
  );

  modport slave (
    output nmem, nio, nr, nwen, nhalt, nwaitext,
    input  nmemrd, nmemwr, niord, niowr, nws, nbuserr, busy
  );

endinterface

// File: rtl/bus_cycle_controller_wait_state_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
// Used for wait states and, when enabled, for the bus timeout.
module wait_state_counter
  import bus_cycle_controller_pkg::*;
#(
  parameter int WIDTH = WS_BITS
) (
  input  logic             clk4,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk4) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/bus_cycle_controller.sv
// Turns decoded sequencer bus fields into timed memory/I-O strobes with wait states.
// Optional bus timeout on stuck nwaitext: define BUS_TIMEOUT_EN.
module bus_cycle_controller
  import bus_cycle_controller_pkg::*;
#(
  parameter int MEM_WS  = 0,
  parameter int IO_WS   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk4,
  input  logic                   reset,
  bus_cycle_controller_if.master bus
);

  if ((MEM_WS < 0) || (MEM_WS > 15) || (IO_WS < 0) || (IO_WS > 15) || (TIMEOUT < 1)) begin : g_param_check
    $error("bus_cycle_controller: wait states must be 0..15 and TIMEOUT >= 1");
  end

  bus_state_t              state_reg, state_next;
  logic [NUM_STROBES-1:0]  strobe_n_reg, strobe_n_next;
  logic                    nws_reg, nws_next;
  logic                    nbuserr_reg, nbuserr_next;
  logic                    busy_reg, busy_next;

  logic                    req_valid;
  logic                    req_illegal;
  cycle_type_t             req_type;

  logic                    ws_load;
  logic                    ws_dec;
  logic                    ws_zero;
  logic [WS_BITS-1:0]      ws_load_value;

  assign req_valid   = (bus.nmem ^ bus.nio) & (bus.nr ^ bus.nwen);
  assign req_illegal = (~bus.nmem & ~bus.nio) | ((bus.nmem ^ bus.nio) & ~bus.nr & ~bus.nwen);
  // Only meaningful when req_valid: nio low means I/O space, nr high means write.
  assign req_type    = cycle_type_t'({~bus.nio, bus.nr});

  assign ws_load_value = is_mem_cycle(req_type) ? WS_BITS'(MEM_WS) : WS_BITS'(IO_WS);

  wait_state_counter #(
    .WIDTH (WS_BITS)
  ) u_wait_state_counter (
    .clk4       (clk4),
    .reset      (reset),
    .load       (ws_load),
    .load_value (ws_load_value),
    .dec        (ws_dec),
    .zero       (ws_zero)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TO_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic to_load;
  logic to_dec;
  logic to_zero;

  // Loaded with TIMEOUT-1 so the TIMEOUT-th stalled edge sees zero and releases.
  wait_state_counter #(
    .WIDTH (TO_BITS)
  ) u_timeout_counter (
    .clk4       (clk4),
    .reset      (reset),
    .load       (to_load),
    .load_value (TO_BITS'(TIMEOUT - 1)),
    .dec        (to_dec),
    .zero       (to_zero)
  );
`endif

  always_ff @(posedge clk4) begin
    if (reset) begin
      state_reg    <= IDLE;
      strobe_n_reg <= '1;
      nws_reg      <= 1'b1;
      nbuserr_reg  <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      strobe_n_reg <= strobe_n_next;
      nws_reg      <= nws_next;
      nbuserr_reg  <= nbuserr_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    strobe_n_next = strobe_n_reg;
    nws_next      = nws_reg;
    nbuserr_next  = 1'b1;
    busy_next     = busy_reg;
    ws_load       = 1'b0;
    ws_dec        = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_load       = 1'b0;
    to_dec        = 1'b0;
`endif

    case (state_reg)
      IDLE, RELEASE: begin
        if (bus.nhalt && req_valid) begin
          state_next    = STROBE;
          strobe_n_next = strobe_pattern(req_type);
          nws_next      = 1'b0;
          busy_next     = 1'b1;
          ws_load       = 1'b1;
`ifdef BUS_TIMEOUT_EN
          to_load       = 1'b1;
`endif
        end else begin
          state_next    = IDLE;
          strobe_n_next = '1;
          nws_next      = 1'b1;
          busy_next     = 1'b0;
          nbuserr_next  = ~(bus.nhalt & req_illegal);
        end
      end

      STROBE: begin
        if (!ws_zero) begin
          ws_dec = 1'b1;
        end else if (bus.nwaitext) begin
          state_next    = RELEASE;
          strobe_n_next = '1;
          nws_next      = 1'b1;
          busy_next     = 1'b0;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_zero) begin
          state_next    = RELEASE;
          strobe_n_next = '1;
          nws_next      = 1'b1;
          busy_next     = 1'b0;
          nbuserr_next  = 1'b0;
        end else begin
          to_dec = 1'b1;
        end
`endif
      end

      default: begin
        state_next    = IDLE;
        strobe_n_next = '1;
        nws_next      = 1'b1;
        busy_next     = 1'b0;
      end
    endcase
  end

  assign bus.nmemrd  = strobe_n_reg[MEMRD];
  assign bus.nmemwr  = strobe_n_reg[MEMWR];
  assign bus.niord   = strobe_n_reg[IORD];
  assign bus.niowr   = strobe_n_reg[IOWR];
  assign bus.nws     = nws_reg;
  assign bus.nbuserr = nbuserr_reg;
  assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller: expected output vectors are queued as each
// request is driven and compared after the following clock edge.
module tb_bus_cycle_controller;

  logic clk4  = 1'b0;
  logic reset = 1'b1;

  bus_cycle_controller_if bus ();

  bus_cycle_controller #(
    .MEM_WS  (0),
    .IO_WS   (2),
    .TIMEOUT (64)
  ) dut (
    .clk4  (clk4),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk4 = ~clk4;

  // Output vector: {nmemrd, nmemwr, niord, niowr, nws, nbuserr, busy}
  localparam logic [6:0] O_IDLE   = 7'b1111_110;
  localparam logic [6:0] O_MEMRD  = 7'b0111_011;
  localparam logic [6:0] O_MEMWR  = 7'b1011_011;
  localparam logic [6:0] O_IORD   = 7'b1101_011;
  localparam logic [6:0] O_IOWR   = 7'b1110_011;
  localparam logic [6:0] O_BUSERR = 7'b1111_100;

  // Request vector: {nmem, nio, nr, nwen}
  localparam logic [3:0] R_NONE  = 4'b1111;
  localparam logic [3:0] R_MEMRD = 4'b0101;
  localparam logic [3:0] R_MEMWR = 4'b0110;
  localparam logic [3:0] R_IORD  = 4'b1001;
  localparam logic [3:0] R_IOWR  = 4'b1010;
  localparam logic [3:0] R_BOTH  = 4'b0001;
  localparam logic [3:0] R_RW    = 4'b0100;
  localparam logic [3:0] R_NODIR = 4'b0111;

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  function automatic logic [6:0] observed();
    return {bus.nmemrd, bus.nmemwr, bus.niord, bus.niowr, bus.nws, bus.nbuserr, bus.busy};
  endfunction

  task automatic check_output();
    exp_t       e;
    logic [6:0] obs;
    obs = observed();
    assert_count++;
    if (sb_q.size() == 0) begin
      fail_count++;
      $error("FAIL scoreboard_empty: observed %b expected an entry", obs);
    end else begin
      e = sb_q.pop_front();
      $display("%-18s observed %b expected %b", e.tag, obs, e.exp);
      assert (obs === e.exp) else begin
        fail_count++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input logic [3:0] req, input logic nwait, input logic [6:0] exp, input string tag);
    exp_t e;
    @(negedge clk4);
    {bus.nmem, bus.nio, bus.nr, bus.nwen} = req;
    bus.nwaitext = nwait;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk4);
    #1;
    check_output();
  endtask

  initial begin
    {bus.nmem, bus.nio, bus.nr, bus.nwen} = R_NONE;
    bus.nhalt    = 1'b1;
    bus.nwaitext = 1'b1;
    reset        = 1'b1;

    step(R_NONE, 1'b1, O_IDLE, "reset_0");
    step(R_MEMRD, 1'b1, O_IDLE, "reset_1_req");
    reset = 1'b0;
    step(R_NONE, 1'b1, O_IDLE, "idle");

    // Memory read, zero wait states
    step(R_MEMRD, 1'b1, O_MEMRD, "t1_memrd");
    step(R_NONE, 1'b1, O_IDLE, "t1_release");
    step(R_NONE, 1'b1, O_IDLE, "t1_idle");

    // I/O write, two wait states; request and nwaitext changes mid-cycle are ignored
    step(R_IOWR, 1'b1, O_IOWR, "t2_iowr_c0");
    step(R_MEMRD, 1'b1, O_IOWR, "t2_iowr_c1");
    step(R_MEMRD, 1'b0, O_IOWR, "t2_iowr_c2");
    step(R_NONE, 1'b1, O_IDLE, "t2_release");
    step(R_NONE, 1'b1, O_IDLE, "t2_idle");

    // External wait held for five cycles after entry
    step(R_MEMRD, 1'b0, O_MEMRD, "t3_accept");
    for (int i = 0; i < 5; i++) step(R_NONE, 1'b0, O_MEMRD, "t3_extwait");
    step(R_NONE, 1'b1, O_IDLE, "t3_release");
    step(R_NONE, 1'b1, O_IDLE, "t3_idle");

    // Illegal and incomplete requests
    step(R_BOTH, 1'b1, O_BUSERR, "t4_memio_err");
    step(R_NONE, 1'b1, O_IDLE, "t4_err_clear");
    step(R_RW, 1'b1, O_BUSERR, "t4_rw_err");
    step(R_NONE, 1'b1, O_IDLE, "t4_err_clear2");
    step(R_NODIR, 1'b1, O_IDLE, "t4_nodir");

    // Back-to-back memory writes, then reset in the middle of an I/O read
    step(R_MEMWR, 1'b1, O_MEMWR, "t5_wr1");
    step(R_MEMWR, 1'b1, O_IDLE, "t5_turnaround");
    step(R_MEMWR, 1'b1, O_MEMWR, "t5_wr2");
    step(R_NONE, 1'b1, O_IDLE, "t5_release");
    step(R_IORD, 1'b1, O_IORD, "t5_iord");
    step(R_IORD, 1'b1, O_IORD, "t5_iord_ws");
    reset = 1'b1;
    step(R_IORD, 1'b1, O_IDLE, "t5_reset_mid");
    step(R_IORD, 1'b1, O_IDLE, "t5_reset_hold");
    reset = 1'b0;
    step(R_NONE, 1'b1, O_IDLE, "t5_after_reset");

    // Halt blocks acceptance but lets an in-flight cycle finish
    bus.nhalt = 1'b0;
    step(R_MEMRD, 1'b1, O_IDLE, "t6_halt_block");
    bus.nhalt = 1'b1;
    step(R_IORD, 1'b1, O_IORD, "t6_accept");
    bus.nhalt = 1'b0;
    step(R_IORD, 1'b1, O_IORD, "t6_halted_ws1");
    step(R_IORD, 1'b1, O_IORD, "t6_halted_ws0");
    step(R_IORD, 1'b1, O_IDLE, "t6_release");
    step(R_IORD, 1'b1, O_IDLE, "t6_halt_idle");
    bus.nhalt = 1'b1;
    step(R_NONE, 1'b1, O_IDLE, "t6_idle");

    // Stuck external wait
    step(R_MEMRD, 1'b0, O_MEMRD, "t7_accept");
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 63; i++) step(R_NONE, 1'b0, O_MEMRD, "t7_stall");
    step(R_NONE, 1'b0, O_BUSERR, "t7_timeout");
    step(R_NONE, 1'b0, O_IDLE, "t7_idle");
`else
    for (int i = 0; i < 100; i++) step(R_NONE, 1'b0, O_MEMRD, "t7_stall");
    step(R_NONE, 1'b1, O_IDLE, "t7_release");
    step(R_NONE, 1'b1, O_IDLE, "t7_idle");
`endif

    assert_count++;
    assert (sb_q.size() == 0) else begin
      fail_count++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
